noc_endpoint_rx: RTL

//  Multi-channel NoC packet receiver: the sink end of a compute tile's noc_out_* port.

---
 rtl/noc_endpoint_pkg.sv | 12 +
 rtl/noc_rx_fifo.sv | 45 ++++
 rtl/noc_endpoint_rx.sv | 92 +++++++++
 3 files changed

// File: rtl/noc_endpoint_pkg.sv
// noc_endpoint_pkg: shared flit type, arbiter states and channel-index width helper for noc_endpoint_rx
package noc_endpoint_pkg;
  localparam int NOC_FLIT_WIDTH = 32;
  typedef struct packed {
    logic                      last;
    logic [NOC_FLIT_WIDTH-1:0] data;
  } flit_t;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  function automatic int chan_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction
endpackage

// File: rtl/noc_rx_fifo.sv
// noc_rx_fifo: per-channel flit FIFO (wr_* push, rd_en pop, full/empty, head_*, wr/rd last-flit strobes)
module noc_rx_fifo
  import noc_endpoint_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FLIT_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  empty,
  output logic [FLIT_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic                  wr_last_stb,
  output logic                  rd_last_stb
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FLIT_WIDTH:0] mem_q [DEPTH];
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, wr_data};
  end
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign {head_last, head_data} = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_last_stb = wr_en && wr_last;
  assign rd_last_stb = rd_en && head_last;
endmodule

// File: rtl/noc_endpoint_rx.sv
// noc_endpoint_rx: store-and-forward multi-VC NoC sink (noc_in_* per-channel flits in, out_* round-robin packet stream, err_oversize sticky)
module noc_endpoint_rx
  import noc_endpoint_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] noc_in_flit,
  input  logic [CHANNELS-1:0]                 noc_in_last,
  input  logic [CHANNELS-1:0]                 noc_in_valid,
  output logic [CHANNELS-1:0]                 noc_in_ready,
  output logic [FLIT_WIDTH-1:0]               out_flit,
  output logic                                out_last,
  output logic [chan_w(CHANNELS)-1:0]         out_chan,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHANNELS-1:0]                 err_oversize
);
  localparam int CW = chan_w(CHANNELS);
  localparam int PW = $clog2(DEPTH) + 1;
  logic [CHANNELS-1:0] full, empty, head_last, push, pop, cand, wr_last_stb, rd_last_stb;
  logic [FLIT_WIDTH-1:0] head_data [CHANNELS];
  logic [PW-1:0] pkt_cnt_q [CHANNELS];
  logic [PW-1:0] pkt_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] err_q, err_d;
  logic rdy_q;
  arb_state_e state_q, state_d;
  logic [CW-1:0] chan_q, chan_d, rr_q, rr_d, grant, idx, sel;
  logic any_cand, fire, fire_last;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    noc_rx_fifo #(.FLIT_WIDTH(FLIT_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk, .rst_n,
      .wr_en(push[i]), .wr_data(noc_in_flit[i]), .wr_last(noc_in_last[i]),
      .rd_en(pop[i]), .full(full[i]), .empty(empty[i]),
      .head_data(head_data[i]), .head_last(head_last[i]),
      .wr_last_stb(wr_last_stb[i]), .rd_last_stb(rd_last_stb[i])
    );
    assign pop[i] = fire && sel == CW'(i);
    // a full FIFO with no complete packet holds an oversize packet: let it cut through
    assign cand[i] = pkt_cnt_q[i] != '0 || full[i];
    assign pkt_cnt_d[i] = pkt_cnt_q[i] + PW'(wr_last_stb[i]) - PW'(rd_last_stb[i]);
    assign err_d[i] = err_q[i] | (full[i] && pkt_cnt_q[i] == '0);
  end
  // descending scan so the candidate closest at/after rr_q wins
  always_comb begin
    grant = rr_q;
    idx = '0;
    any_cand = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = CW'((int'(rr_q) + k) % CHANNELS);
      if (cand[idx]) begin
        grant = idx;
        any_cand = 1'b1;
      end
    end
  end
  assign sel = state_q == BUSY ? chan_q : grant;
  assign out_valid = (state_q == BUSY || any_cand) && !empty[sel];
  assign fire = out_valid && out_ready;
  assign fire_last = fire && head_last[sel];
  assign out_flit = out_valid ? head_data[sel] : '0;
  assign out_last = out_valid && head_last[sel];
  assign out_chan = sel;
  assign noc_in_ready = {CHANNELS{rdy_q}} & ~full;
  assign push = noc_in_valid & noc_in_ready;
  assign err_oversize = err_q;
  always_comb begin
    state_d = fire_last ? IDLE : (state_q == BUSY || any_cand) ? BUSY : IDLE;
    chan_d = (state_q == IDLE && any_cand) ? grant : chan_q;
    rr_d = fire_last ? CW'((int'(sel) + 1) % CHANNELS) : rr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chan_q <= '0;
      rr_q <= '0;
      err_q <= '0;
      rdy_q <= 1'b0;
      pkt_cnt_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      chan_q <= chan_d;
      rr_q <= rr_d;
      err_q <= err_d;
      rdy_q <= 1'b1;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
endmodule
